// File: rtl/timer_pkg.sv
// Shared types and default widths for the timer register-port blocks.
package timer_pkg;

    localparam int TIMER_ADDR_W = 6;
    localparam int TIMER_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

endpackage

// File: rtl/timer_rr_pick.sv
// Combinational round-robin picker: first eligible requester after last_winner.
module timer_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IW-1:0]      last_winner,
    output logic [IW-1:0]      winner,
    output logic               any_valid
);

    logic [IW-1:0] idx;

    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(last_winner) + k) % NUM_REQ);
            if (!any_valid && eligible[idx]) begin
                any_valid = 1'b1;
                winner    = idx;
            end
        end
    end

endmodule

// File: rtl/timer_reg_arbiter.sv
// Round-robin arbiter sharing the timer register port between NUM_REQ masters,
// with an optional per-master lock for atomic read-modify-write sequences.
module timer_reg_arbiter
    import timer_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_W       = TIMER_ADDR_W,
    parameter int DATA_W       = TIMER_DATA_W,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         we,
    input  logic [NUM_REQ-1:0]         lock,
    input  logic [NUM_REQ*ADDR_W-1:0]  addr,
    input  logic [NUM_REQ*DATA_W-1:0]  wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         rvalid,
    output logic [DATA_W-1:0]          rdata,
    output logic [ADDR_W-1:0]          t_addr,
    output logic                       t_wr_en,
    output logic [DATA_W-1:0]          t_wdata,
    input  logic [DATA_W-1:0]          t_rdata
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_TIMEOUT);

    arb_state_t          state_reg, state_next;
    logic [IW-1:0]       winner_reg, last_winner_reg, owner_reg, pick;
    logic                any_valid, we_reg, lock_req_reg, locked_reg;
    logic [CW-1:0]       cnt_reg;
    logic [ADDR_W-1:0]   t_addr_reg;
    logic [DATA_W-1:0]   t_wdata_reg, rdata_reg;
    logic [NUM_REQ-1:0]  owner_mask, eligible;
    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_per_master
        assign addr_arr[gi]   = addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi]  = wdata[gi*DATA_W +: DATA_W];
        assign owner_mask[gi] = (owner_reg == IW'(gi));
        assign gnt[gi]        = (state_reg == ACCESS) && (winner_reg == IW'(gi));
        assign rvalid[gi]     = (state_reg == RESP) && (winner_reg == IW'(gi));
    end

    // While locked, only the owner may compete.
    assign eligible = locked_reg ? (req & owner_mask) : req;

    timer_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .eligible    (eligible),
        .last_winner (last_winner_reg),
        .winner      (pick),
        .any_valid   (any_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_valid) state_next = ACCESS;
            ACCESS:  state_next = we_reg ? IDLE : RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            winner_reg      <= '0;
            last_winner_reg <= IW'(NUM_REQ - 1);
            owner_reg       <= '0;
            we_reg          <= 1'b0;
            lock_req_reg    <= 1'b0;
            locked_reg      <= 1'b0;
            cnt_reg         <= '0;
            t_addr_reg      <= '0;
            t_wdata_reg     <= '0;
            rdata_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_valid) begin
                        winner_reg      <= pick;
                        last_winner_reg <= pick;
                        we_reg          <= we[pick];
                        lock_req_reg    <= lock[pick];
                        t_addr_reg      <= addr_arr[pick];
                        t_wdata_reg     <= wdata_arr[pick];
                        cnt_reg         <= '0;
                    end else if (locked_reg && !req[owner_reg]) begin
                        // Owner has gone quiet: count toward a forced release.
                        if (cnt_reg + CW'(1) == CNT_MAX) begin
                            locked_reg <= 1'b0;
                            cnt_reg    <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end
                end
                ACCESS: begin
                    if (!we_reg) rdata_reg <= t_rdata;
                    if (lock_req_reg) begin
                        locked_reg <= 1'b1;
                        owner_reg  <= winner_reg;
                    end else if (locked_reg && owner_reg == winner_reg) begin
                        locked_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign t_wr_en = (state_reg == ACCESS) && we_reg;
    assign t_addr  = t_addr_reg;
    assign t_wdata = t_wdata_reg;
    assign rdata   = rdata_reg;

endmodule

// File: tb/tb_timer_reg_arbiter.sv
// Directed plus randomized bench for timer_reg_arbiter against a cycle-level reference model.
module tb_timer_reg_arbiter;

    localparam int N  = 2;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int LT = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0, we = '0, lock = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata, t_wdata, t_rdata;
    logic [AW-1:0]   t_addr;
    logic            t_wr_en;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] timer_model(logic [AW-1:0] a);
        return {a, 2'b00} ^ 8'h2C;
    endfunction

    assign t_rdata = timer_model(t_addr);

    timer_reg_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LOCK_TIMEOUT(LT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .t_addr(t_addr), .t_wr_en(t_wr_en), .t_wdata(t_wdata), .t_rdata(t_rdata)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: stage 0 waiting, 1 register access, 2 read response.
    int            m_stage, m_cur, m_last, m_owner, m_idle;
    bit            m_write, m_lockreq;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    logic [N-1:0]  o_gnt, o_rvalid;
    logic          o_wr;
    logic [DW-1:0] o_rdata, o_twdata;
    logic [AW-1:0] o_taddr;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_stage = 0; m_cur = 0; m_last = N - 1; m_owner = -1; m_idle = 0;
        m_write = 0; m_lockreq = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    endtask

    task automatic model_edge();
        int w;
        if (rst) begin
            model_reset();
        end else if (m_stage == 0) begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (w < 0 && req[i] && (m_owner < 0 || m_owner == i)) w = i;
            end
            if (w >= 0) begin
                m_cur = w; m_last = w; m_write = we[w]; m_lockreq = lock[w];
                m_addr = addr[w*AW +: AW]; m_wdata = wdata[w*DW +: DW];
                m_stage = 1; m_idle = 0;
            end else if (m_owner >= 0 && !req[m_owner]) begin
                m_idle++;
                if (m_idle == LT) begin
                    m_owner = -1;
                    m_idle  = 0;
                end
            end
        end else if (m_stage == 1) begin
            if (!m_write) m_rdata = timer_model(m_addr);
            if (m_lockreq) m_owner = m_cur;
            else if (m_owner == m_cur) m_owner = -1;
            m_stage = m_write ? 0 : 2;
        end else begin
            m_stage = 0;
        end
    endtask

    // Compare one cycle at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        logic [N-1:0] eg, ev;
        @(negedge clk);
        o_gnt = gnt; o_rvalid = rvalid; o_wr = t_wr_en; o_rdata = rdata;
        o_taddr = t_addr; o_twdata = t_wdata;
        eg = (m_stage == 1) ? (N'(1) << m_cur) : '0;
        ev = (m_stage == 2) ? (N'(1) << m_cur) : '0;
        chk("gnt", 32'(o_gnt), 32'(eg));
        chk("rvalid", 32'(o_rvalid), 32'(ev));
        chk("t_wr_en", 32'(o_wr), 32'(m_stage == 1 && m_write));
        chk("t_addr", 32'(o_taddr), 32'(m_addr));
        chk("t_wdata", 32'(o_twdata), 32'(m_wdata));
        if (ev != '0) chk("rdata", 32'(o_rdata), 32'(m_rdata));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_m(int i, bit r, bit w, bit l, logic [AW-1:0] a, logic [DW-1:0] d);
        req[i] = r; we[i] = w; lock[i] = l;
        addr[i*AW +: AW] = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        req = '0; rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    bit [N-1:0] pending;

    initial begin
        @(posedge clk);
        model_reset();
        #1;
        cycle();
        chk("rst_gnt", 32'(o_gnt), 0);
        chk("rst_rvalid", 32'(o_rvalid), 0);
        chk("rst_t_addr", 32'(o_taddr), 0);
        chk("rst_rdata", 32'(o_rdata), 0);
        rst = 1'b0;

        // Single write from master 0.
        set_m(0, 1, 1, 0, 6'h04, 8'hA5);
        cycle();
        cycle();
        chk("w_gnt", 32'(o_gnt), 32'h1);
        chk("w_wr_en", 32'(o_wr), 1);
        chk("w_addr", 32'(o_taddr), 32'h04);
        chk("w_wdata", 32'(o_twdata), 32'hA5);
        req = '0;
        cycle();
        chk("w_wr_once", 32'(o_wr), 0);
        chk("w_no_rvalid", 32'(o_rvalid), 0);

        // Read from master 1.
        set_m(1, 1, 0, 0, 6'h04, 8'h00);
        cycle();
        cycle();
        chk("r_gnt", 32'(o_gnt), 32'h2);
        chk("r_wr_en", 32'(o_wr), 0);
        req = '0;
        cycle();
        chk("r_rvalid", 32'(o_rvalid), 32'h2);
        chk("r_rdata", 32'(o_rdata), 32'h3C);
        chk("r_wr_en2", 32'(o_wr), 0);
        cycle();

        // Contention from reset: both masters write continuously.
        do_reset();
        set_m(0, 1, 1, 0, 6'h01, 8'h11);
        set_m(1, 1, 1, 0, 6'h02, 8'h22);
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("cont_gnt", 32'(o_gnt), (k % 2 == 0) ? 0 : (((k / 2) % 2 == 0) ? 1 : 2));
        end
        req = '0;
        cycle();

        // Lock: master 0 read(lock) then write(unlock) ahead of master 1.
        do_reset();
        set_m(0, 1, 0, 1, 6'h08, 8'h00);
        set_m(1, 1, 1, 0, 6'h09, 8'h99);
        cycle();
        cycle();
        chk("lock_g1", 32'(o_gnt), 1);
        set_m(0, 1, 1, 0, 6'h08, 8'h5A);
        cycle();
        chk("lock_rv", 32'(o_rvalid), 1);
        cycle();
        chk("lock_idle", 32'(o_gnt), 0);
        cycle();
        chk("lock_g2", 32'(o_gnt), 1);
        req[0] = 1'b0;
        cycle();
        cycle();
        chk("lock_g3", 32'(o_gnt), 2);
        req = '0;
        cycle();

        // Lock timeout: master 0 locks then goes quiet.
        do_reset();
        set_m(0, 1, 1, 1, 6'h10, 8'h55);
        cycle();
        cycle();
        chk("to_g0", 32'(o_gnt), 1);
        req[0] = 1'b0;
        set_m(1, 1, 1, 0, 6'h11, 8'h66);
        for (int k = 0; k < LT + 1; k++) begin
            cycle();
            chk("to_wait", 32'(o_gnt), 0);
        end
        cycle();
        chk("to_g1", 32'(o_gnt), 2);
        cycle();
        cycle();
        chk("to_free", 32'(o_gnt), 2);
        req = '0;
        cycle();

        // Reset in the ACCESS cycle of a read.
        do_reset();
        set_m(0, 1, 0, 0, 6'h04, 8'h00);
        cycle();
        rst = 1'b1;
        req = '0;
        cycle();
        chk("rr_gnt", 32'(o_gnt), 1);
        rst = 1'b0;
        cycle();
        chk("rr_gnt0", 32'(o_gnt), 0);
        chk("rr_rvalid", 32'(o_rvalid), 0);
        chk("rr_rdata", 32'(o_rdata), 0);
        chk("rr_taddr", 32'(o_taddr), 0);
        chk("rr_wr", 32'(o_wr), 0);
        set_m(0, 1, 0, 0, 6'h05, 8'h00);
        set_m(1, 1, 0, 0, 6'h06, 8'h00);
        cycle();
        chk("rr_after", 32'(o_rvalid), 0);
        cycle();
        chk("rr_first", 32'(o_gnt), 1);
        req = '0;
        cycle();
        cycle();
        cycle();

        // Randomized traffic honouring the hold-until-gnt protocol.
        pending = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (o_gnt[i]) pending[i] = 1'b0;
                if (!pending[i]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        set_m(i, 1, 1'($urandom), ($urandom_range(0, 3) == 0),
                              AW'($urandom), DW'($urandom));
                        pending[i] = 1'b1;
                    end else begin
                        req[i] = 1'b0;
                    end
                end
            end
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
